// File: rtl/ram_pkg.sv
// Shared state encoding and helpers for the ram_ctrl memory block.
package ram_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    typedef logic [1:0] state_t;

    function automatic int byte_cnt(input int data_w);
        return data_w / 8;
    endfunction

    // Even parity: the stored bit makes the byte plus parity carry an even number of ones.
    function automatic logic even_par(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/ram_array.sv
// Word storage with byte-enable write port and registered read port.
// Per-byte even-parity storage is added when RAM_PARITY_EN is defined.
module ram_array
    import ram_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16384,
    parameter int IDX_W  = 14
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   be,
    input  logic                  re,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_W-1:0]     q
`ifdef RAM_PARITY_EN
    ,
    output logic                  q_perr
`endif
);

    localparam int NB = byte_cnt(DATA_W);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            q <= mem[raddr];
        end
    end

`ifdef RAM_PARITY_EN
    logic [NB-1:0] par [DEPTH];
    logic [NB-1:0] rd_bad;

    always_comb begin
        rd_bad = '0;
        for (int i = 0; i < NB; i++) begin
            rd_bad[i] = even_par(mem[raddr][8*i +: 8]) ^ par[raddr][i];
        end
    end

    // Parity is recomputed for every byte on read, regardless of which bytes were last written.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    par[waddr][i] <= even_par(wdata[8*i +: 8]);
                end
            end
        end
        if (re) begin
            q_perr <= |rd_bad;
        end
    end
`endif

endmodule

// File: rtl/ram_ctrl.sv
// Single-port RAM with registered req/rdy/ack handshake, wait states and range check.
// Optional per-byte parity checking is enabled by defining RAM_PARITY_EN.
module ram_ctrl
    import ram_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int DEPTH    = 16384,
    parameter int WAIT_CYC = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  req,
    input  logic                  write,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   be,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rdy,
    output logic                  ack,
    output logic                  rvalid,
    output logic                  err,
    output logic                  perr
);

    localparam int              NB      = byte_cnt(DATA_W);
    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0]      WAIT_LD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    state_t            state, state_nx;
    logic [3:0]        wcnt;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic [NB-1:0]     be_p0;
    logic              write_p0;
    logic              accept, in_range, oor_p0, mem_we, mem_re;
    logic [DATA_W-1:0] mem_q;

    assign accept   = (state == ST_IDLE) && cs && req;
    assign in_range = {1'b0, addr} < DEPTH_L;
    assign oor_p0   = !({1'b0, addr_p0} < DEPTH_L);
    // The read is launched at the accepting edge so the word is ready during ACCESS.
    assign mem_re   = accept && !write && in_range;
    assign mem_we   = (state == ST_ACCESS) && write_p0 && !oor_p0;

    // Request capture stage (accepting edge)
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p0  <= addr;
            wdata_p0 <= wdata;
            be_p0    <= be;
            write_p0 <= write;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (accept) state_nx = ST_ACCESS;
            ST_ACCESS: state_nx = (WAIT_CYC > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT:   if (wcnt == 4'd0) state_nx = ST_RESP;
            ST_RESP:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Control and response stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            wcnt   <= 4'd0;
            rdy    <= 1'b1;
            ack    <= 1'b0;
            rvalid <= 1'b0;
            err    <= 1'b0;
            rdata  <= '0;
        end else begin
            state  <= state_nx;
            rdy    <= (state_nx == ST_IDLE);
            ack    <= (state_nx == ST_RESP);
            rvalid <= (state_nx == ST_RESP) && !write_p0;
            err    <= (state_nx == ST_RESP) && oor_p0;
            if (state == ST_ACCESS) begin
                wcnt <= WAIT_LD;
            end else if (state == ST_WAIT && wcnt != 4'd0) begin
                wcnt <= wcnt - 4'd1;
            end
            if (state == ST_ACCESS && !write_p0) begin
                rdata <= oor_p0 ? '0 : mem_q;
            end
        end
    end

`ifdef RAM_PARITY_EN
    logic mem_perr;

    // The array's parity flag holds from the launching read until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr <= 1'b0;
        end else begin
            perr <= (state_nx == ST_RESP) && !write_p0 && !oor_p0 && mem_perr;
        end
    end
`else
    assign perr = 1'b0;
`endif

    ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk    (clk),
        .we     (mem_we),
        .waddr  (addr_p0[IDX_W-1:0]),
        .wdata  (wdata_p0),
        .be     (be_p0),
        .re     (mem_re),
        .raddr  (addr[IDX_W-1:0]),
        .q      (mem_q)
`ifdef RAM_PARITY_EN
        ,
        .q_perr (mem_perr)
`endif
    );

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: two instances (no wait states / three wait states, 1000 words)
// checked every cycle against a transaction-level model plus directed literal checks.
module tb_ram_ctrl;

    localparam int DEPTH = 1000;
    localparam int W0    = 0;
    localparam int W1    = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       cs, req, write;
    logic [1:0][15:0] addr, wdata, rdata;
    logic [1:0][1:0]  be;
    logic [1:0]       rdy, ack, rvalid, err, perr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ram_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .WAIT_CYC(W0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cs(cs[0]), .req(req[0]), .write(write[0]),
        .addr(addr[0]), .wdata(wdata[0]), .be(be[0]), .rdata(rdata[0]),
        .rdy(rdy[0]), .ack(ack[0]), .rvalid(rvalid[0]), .err(err[0]), .perr(perr[0])
    );

    ram_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .WAIT_CYC(W1)) dut3 (
        .clk(clk), .rst_n(rst_n), .cs(cs[1]), .req(req[1]), .write(write[1]),
        .addr(addr[1]), .wdata(wdata[1]), .be(be[1]), .rdata(rdata[1]),
        .rdy(rdy[1]), .ack(ack[1]), .rvalid(rvalid[1]), .err(err[1]), .perr(perr[1])
    );

    function automatic int wc(input int d);
        return (d == 1) ? W1 : W0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: accepted at edge E0, commits at E0+1, ack after E0+1+W,
    // idle again from E0+2+W.
    logic [15:0] mmem [2][DEPTH];
    logic [1:0]  mbad [2][DEPTH];
    int          m_n = 0;
    bit          m_pend [2];
    int          m_e0   [2];
    bit          m_wr   [2];
    int          m_a    [2];
    logic [15:0] m_wd   [2];
    logic [1:0]  m_be   [2];
    logic [15:0] m_rdata[2];
    bit          m_pbad [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = 0; m_rdata[d] = '0; m_pbad[d] = 0; m_e0[d] = 0;
            for (int a = 0; a < DEPTH; a++) mbad[d][a] = '0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int d = 0; d < 2; d++) begin
                    m_pend[d] = 0;
                    m_rdata[d] = '0;
                end
            end else begin
                m_n++;
                for (int d = 0; d < 2; d++) begin
                    if (m_pend[d]) begin
                        if (m_n - m_e0[d] == 1) begin
                            if (m_a[d] < DEPTH) begin
                                if (m_wr[d]) begin
                                    for (int i = 0; i < 2; i++) begin
                                        if (m_be[d][i]) begin
                                            mmem[d][m_a[d]][8*i +: 8] = m_wd[d][8*i +: 8];
                                            mbad[d][m_a[d]][i] = 1'b0;
                                        end
                                    end
                                end else begin
                                    m_rdata[d] = mmem[d][m_a[d]];
                                    m_pbad[d]  = |mbad[d][m_a[d]];
                                end
                            end else if (!m_wr[d]) begin
                                m_rdata[d] = '0;
                                m_pbad[d]  = 0;
                            end
                        end
                        if (m_n - m_e0[d] == 2 + wc(d)) m_pend[d] = 0;
                    end else if (cs[d] && req[d]) begin
                        m_pend[d] = 1;
                        m_e0[d]   = m_n;
                        m_wr[d]   = write[d];
                        m_a[d]    = int'(addr[d]);
                        m_wd[d]   = wdata[d];
                        m_be[d]   = be[d];
                    end
                end
            end
        end
    end

    // Per-cycle compare of every output of both instances against the model.
    initial begin
        forever begin
            int   k;
            logic ea, eperr;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                k  = m_n - m_e0[d];
                ea = m_pend[d] && (k == 1 + wc(d));
`ifdef RAM_PARITY_EN
                eperr = ea && !m_wr[d] && (m_a[d] < DEPTH) && m_pbad[d];
`else
                eperr = 1'b0;
`endif
                chk($sformatf("cyc_rdy%0d", d),    rdy[d],    !m_pend[d]);
                chk($sformatf("cyc_ack%0d", d),    ack[d],    ea);
                chk($sformatf("cyc_rvalid%0d", d), rvalid[d], ea && !m_wr[d]);
                chk($sformatf("cyc_err%0d", d),    err[d],    ea && (m_a[d] >= DEPTH));
                chk($sformatf("cyc_perr%0d", d),   perr[d],   eperr);
                chk($sformatf("cyc_rdata%0d", d),  rdata[d],  m_rdata[d]);
            end
        end
    end

    task automatic drive(input int d, input bit wr, input logic [15:0] a,
                         input logic [15:0] wd, input logic [1:0] b);
        cs[d] = 1'b1; req[d] = 1'b1; write[d] = wr;
        addr[d] = a; wdata[d] = wd; be[d] = b;
    endtask

    task automatic idle(input int d);
        cs[d] = 1'b0; req[d] = 1'b0;
    endtask

    // Called just after a falling edge; returns with the instance idle again.
    task automatic txn(input int d, input bit wr, input logic [15:0] a, input logic [15:0] wd,
                       input logic [1:0] b, output logic [15:0] rd, output logic e,
                       output logic pe, output int lat);
        int t;
        t = 0;
        while (!rdy[d] && t < 40) begin @(negedge clk); t++; end
        drive(d, wr, a, wd, b);
        @(negedge clk);
        idle(d);
        lat = 0;
        while (!ack[d] && lat < 40) begin @(negedge clk); lat++; end
        chk($sformatf("ack_seen%0d", d), ack[d], 1'b1);
        rd = rdata[d]; e = err[d]; pe = perr[d];
        @(negedge clk);
        chk($sformatf("rdy_back%0d", d), rdy[d], 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        logic        e, pe;
        int          lat, acks;
        cs = '0; req = '0; write = '0; addr = '0; wdata = '0; be = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rdy", rdy[0], 1'b1);
        chk("reset_rdata", rdata[1], 16'h0);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_rdy", rdy[0], 1'b1);

        // Basic write/read with no wait states
        txn(0, 1'b1, 16'h0010, 16'hA5C3, 2'b11, rd, e, pe, lat);
        chk("w_lat", lat, 1); chk("w_err", e, 1'b0);
        txn(0, 1'b0, 16'h0010, 16'h0000, 2'b11, rd, e, pe, lat);
        chk("r_lat", lat, 1); chk("r_data", rd, 16'hA5C3); chk("r_err", e, 1'b0);

        // Byte enables
        txn(0, 1'b1, 16'd5, 16'h1234, 2'b11, rd, e, pe, lat);
        txn(0, 1'b1, 16'd5, 16'hABCD, 2'b01, rd, e, pe, lat);
        txn(0, 1'b0, 16'd5, 16'h0000, 2'b11, rd, e, pe, lat);
        chk("be01_data", rd, 16'h12CD);
        txn(0, 1'b1, 16'd5, 16'hFFFF, 2'b00, rd, e, pe, lat);
        chk("be00_lat", lat, 1);
        txn(0, 1'b0, 16'd5, 16'h0000, 2'b11, rd, e, pe, lat);
        chk("be00_data", rd, 16'h12CD);

        // Wait states and a request pulsed while busy
        txn(1, 1'b1, 16'd5, 16'h1234, 2'b11, rd, e, pe, lat);
        chk("w3_wlat", lat, 4);
        txn(1, 1'b0, 16'd5, 16'h0000, 2'b11, rd, e, pe, lat);
        chk("w3_rlat", lat, 4); chk("w3_data", rd, 16'h1234);
        drive(1, 1'b0, 16'd5, 16'h0000, 2'b11);
        @(negedge clk);
        drive(1, 1'b1, 16'd5, 16'hDEAD, 2'b11);
        @(negedge clk);
        idle(1);
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            if (ack[1]) acks++;
            @(negedge clk);
        end
        chk("busy_acks", acks, 1);
        txn(1, 1'b0, 16'd5, 16'h0000, 2'b11, rd, e, pe, lat);
        chk("busy_mem", rd, 16'h1234);

        // Out of range
        txn(0, 1'b1, 16'd1000, 16'hBEEF, 2'b11, rd, e, pe, lat);
        chk("oor_werr", e, 1'b1);
        txn(0, 1'b0, 16'd1000, 16'h0000, 2'b11, rd, e, pe, lat);
        chk("oor_rerr", e, 1'b1); chk("oor_rdata", rd, 16'h0);
        txn(0, 1'b1, 16'd999, 16'h0999, 2'b11, rd, e, pe, lat);
        txn(0, 1'b0, 16'd999, 16'h0000, 2'b11, rd, e, pe, lat);
        chk("last_err", e, 1'b0); chk("last_data", rd, 16'h0999);

        // Reset during WAIT after the write has committed
        txn(1, 1'b1, 16'd9, 16'h7777, 2'b11, rd, e, pe, lat);
        drive(1, 1'b1, 16'd9, 16'h8888, 2'b11);
        @(negedge clk);
        idle(1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rdy", rdy[1], 1'b1);
        chk("mid_rst_ack", ack[1], 1'b0);
        chk("mid_rst_rdata", rdata[1], 16'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        txn(1, 1'b0, 16'd9, 16'h0000, 2'b11, rd, e, pe, lat);
        chk("mid_rst_commit", rd, 16'h8888);

        // Parity
        txn(0, 1'b1, 16'd7, 16'h5A5A, 2'b11, rd, e, pe, lat);
`ifdef RAM_PARITY_EN
        dut0.u_array.mem[7][0] = ~dut0.u_array.mem[7][0];
        mmem[0][7][0] = ~mmem[0][7][0];
        mbad[0][7][0] = 1'b1;
        txn(0, 1'b0, 16'd7, 16'h0000, 2'b11, rd, e, pe, lat);
        chk("par_data", rd, 16'h5A5B); chk("par_perr", pe, 1'b1);
`else
        txn(0, 1'b0, 16'd7, 16'h0000, 2'b11, rd, e, pe, lat);
        chk("par_data", rd, 16'h5A5A); chk("par_perr", pe, 1'b0);
`endif

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
- Parametrised single-port synchronous RAM with a registered req/rdy/ack handshake.
- Next generation of the team's 16-bit memory block. Adds:
  - generic width and depth
  - byte-enable writes
  - programmable wait states
  - out-of-range error reporting
  - separate read/write data buses instead of a tristated bus
- Sits on the processor memory bus as a data/program store.

Parameters:
- DATA_W, 16, data width in bits; must be a multiple of 8.
- ADDR_W, 16, address width.
- DEPTH, 16384, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
- WAIT_CYC, 0, extra wait cycles per access, range 0..15.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cs  in  1  chip select.
- req  in  1  transaction request; sampled only with cs.
- write  in  1  1=write, 0=read.
- addr  in  ADDR_W  word address.
- wdata  in  DATA_W  write data.
- be  in  DATA_W/8  byte enables; bit i covers wdata[8i+7:8i].
- rdata  out  DATA_W  read data; valid while rvalid=1.
- rdy  out  1  ready to accept a request.
- ack  out  1  one-cycle transaction-complete pulse, reads and writes.
- rvalid  out  1  one-cycle pulse, reads only, coincident with ack.
- err  out  1  out-of-range flag, valid with ack.
- perr  out  1  parity error flag, valid with rvalid.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, rdy=1, ack=0, rvalid=0, err=0, perr=0, rdata=0.
  - Memory contents are not reset.
- States: IDLE, ACCESS, WAIT, RESP. All outputs are registered.
- IDLE:
  - rdy=1.
  - On an edge where cs&req=1: latch addr, wdata, be, write; go to ACCESS; rdy=0 from that edge.
  - Otherwise stay in IDLE.
- ACCESS, single cycle:
  - addr >= DEPTH: no memory update; read data returned as 0; set err for this transaction.
  - Write: update only the bytes with be[i]=1. be=0 completes normally with no change.
  - Read: capture the addressed word into the rdata holding register.
  - Next state: WAIT if WAIT_CYC>0 (counter loaded with WAIT_CYC-1), else RESP.
- WAIT: decrement counter; go to RESP when counter==0. Holds exactly WAIT_CYC cycles.
- RESP, single cycle:
  - ack=1 and err valid.
  - rvalid=1 and rdata valid for reads.
  - Next edge: IDLE with rdy=1; ack, rvalid, err, perr return to 0.
- Latency: with the accepting edge as E0, ack is high in the cycle after edge E0+1+WAIT_CYC.
- Throughput: one transaction per 3+WAIT_CYC cycles.
- rdata keeps its value after rvalid falls, until the next read.
- Requests while rdy=0 are ignored, not queued. The master must hold req until it sees rdy=1.
- cs=0 with req=1: ignored.
- Read-after-write to the same address returns the new data, since the write commits in ACCESS.
- Reset mid-transaction:
  - A write that has passed the ACCESS edge stays committed.
  - Otherwise the transaction is dropped.
  - No ack is issued; outputs take their reset values immediately.

Optional Feature:
- Macro: RAM_PARITY_EN.
- Defined:
  - Each byte is stored with an even-parity bit, written only for enabled bytes.
  - On read, parity is recomputed for every byte. Any mismatch sets perr=1 with rvalid.
  - Out-of-range reads never set perr.
- Undefined: no parity storage; perr is tied to 0. The port list is unchanged.

Decomposition:
- Package ram_pkg:
  - state enumeration (IDLE/ACCESS/WAIT/RESP)
  - byte-count constant function DATA_W/8
  - even-parity function
- Sub-module ram_array: storage with byte-enable write port and synchronous read, plus parity bits under RAM_PARITY_EN.
- ram_ctrl contains the FSM, wait counter, range check and output registers.

Test Plan:
- Reset then idle: rst_n low → rdy=1, ack=0, rvalid=0, err=0, rdata=0; after release, rdy stays 1 with req=0.
- Write/read, WAIT_CYC=0:
  - Write 0xA5C3 to addr 0x0010 with be=2'b11 → ack in the cycle after E0+1; rdy back high one cycle later.
  - Read 0x0010 → rvalid with rdata=0xA5C3, err=0.
- Byte enables:
  - Preload 0x1234 at addr 5.
  - Write 0xABCD with be=2'b01 → read returns 0x12CD.
  - Write with be=2'b00 → read still returns 0x12CD, ack still pulses.
- Wait states and busy requests, WAIT_CYC=3:
  - Read → ack in the cycle after E0+4.
  - Second request pulsed while rdy=0 → ignored: no second ack, memory unchanged.
- Out of range, DEPTH=1000:
  - Write addr 1000 → ack with err=1.
  - Read addr 1000 → rvalid with rdata=0, err=1.
  - Read addr 999 → err=0.
- Reset mid-op and parity:
  - rst_n pulsed low during WAIT → no ack; rdy=1 immediately.
  - With RAM_PARITY_EN: force-flip a stored bit at addr 7, then read → perr=1 with rvalid.
  - Without RAM_PARITY_EN: perr stays 0.
